// File: rtl/reg_save_restore_pkg.sv
// Shared definitions for the register save/restore sequencer: default
// geometry, state encoding and a small helper for the sequence length.
package reg_save_restore_pkg;

    // Default geometry of the CPU register file and the backup stack.
    localparam int RSR_DATA_W     = 32;
    localparam int RSR_REG_ADDR_W = 4;
    localparam int RSR_FIRST_REG  = 1;   // r0 is hard zero and never saved
    localparam int RSR_LAST_REG   = 15;

    // Sequencer state encoding.
    typedef logic [2:0] rsr_state_t;

    localparam rsr_state_t S_IDLE         = 3'd0;
    localparam rsr_state_t S_SAVE         = 3'd1;
    localparam rsr_state_t S_SAVE_LAST    = 3'd2;
    localparam rsr_state_t S_RESTORE      = 3'd3;
    localparam rsr_state_t S_RESTORE_LAST = 3'd4;
    localparam rsr_state_t S_FINISH       = 3'd5;

    // Number of registers moved by one save or restore.
    function automatic int rsr_seq_len(input int first_reg, input int last_reg);
        return last_reg - first_reg + 1;
    endfunction

endpackage

// File: rtl/reg_save_restore.sv
// Bulk register save/restore initiator. Save streams FIRST_REG..LAST_REG
// from the register file onto the backup stack; restore pops them back in
// reverse order so the register file ends up identical. A stall freezes the
// sequence without losing or duplicating any word.
module reg_save_restore
    import reg_save_restore_pkg::*;
#(
    parameter int DATA_W     = RSR_DATA_W,
    parameter int REG_ADDR_W = RSR_REG_ADDR_W,
    parameter int FIRST_REG  = RSR_FIRST_REG,
    parameter int LAST_REG   = RSR_LAST_REG
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  save_start,
    input  logic                  restore_start,
    input  logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [REG_ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0]     rf_rdata,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  rf_we,
    output logic [DATA_W-1:0]     stk_d,
    output logic                  stk_push,
    output logic                  stk_pop,
    input  logic [DATA_W-1:0]     stk_q,
    output logic                  stk_clear,
    output logic                  stk_hold
);

    localparam logic [REG_ADDR_W-1:0] FIRST_A  = REG_ADDR_W'(FIRST_REG);
    localparam logic [REG_ADDR_W-1:0] LAST_A   = REG_ADDR_W'(LAST_REG);
    // Pop index of the final pop of a restore (N-1).
    localparam logic [REG_ADDR_W-1:0] LAST_CNT =
        REG_ADDR_W'(rsr_seq_len(FIRST_REG, LAST_REG) - 1);

    rsr_state_t            state_q, state_d;
    logic [REG_ADDR_W-1:0] cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0] raddr_q, raddr_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     hold_q, hold_d;
    logic                  hold_vld_q, hold_vld_d;

    logic                  active;
    logic                  run;
    logic                  save_pending;
    logic                  push_w;
    logic                  pop_w;
    logic                  we_w;
    logic [DATA_W-1:0]     save_word;

    // Strobe decode: everything is a function of the current state and stall,
    // so a stall removes the strobe in the very cycle it is raised.
    always_comb begin
        active       = (state_q != S_IDLE);
        run          = active && !stall;
        // rf_rdata carries a word waiting to be pushed in every save cycle
        // except the first one, which only launches the first read.
        save_pending = ((state_q == S_SAVE) && (raddr_q != FIRST_A)) ||
                       (state_q == S_SAVE_LAST);
        push_w       = run && save_pending;
        pop_w        = run && (state_q == S_RESTORE);
        // Writes trail the pops by one cycle: no write on the first pop,
        // the last write happens in RESTORE_LAST with no pop.
        we_w         = run && (((state_q == S_RESTORE) && (cnt_q != '0)) ||
                               (state_q == S_RESTORE_LAST));
        // rf_raddr has already advanced past the pending word when a stall
        // hits, so the register file re-reads the next address during the
        // stall; the pending word is parked in hold_q and pushed on resume.
        save_word    = hold_vld_q ? hold_q : rf_rdata;
    end

    assign busy      = active && (state_q != S_FINISH);
    assign done      = (state_q == S_FINISH) && !stall;
    assign err       = err_q;
    assign rf_raddr  = raddr_q;
    assign rf_waddr  = waddr_q;
    assign rf_we     = we_w;
    assign rf_wdata  = we_w ? stk_q : '0;
    assign stk_push  = push_w;
    assign stk_pop   = pop_w;
    assign stk_d     = push_w ? save_word : '0;
    assign stk_clear = 1'b0;
    assign stk_hold  = 1'b0;

    // Next-state logic for the sequencer, counters and the stall skid word.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        raddr_d    = raddr_q;
        waddr_d    = waddr_q;
        err_d      = 1'b0;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;

        // Park the pending save word on the first stalled cycle only; later
        // stalled cycles already see the re-read of the next address.
        if (stall && save_pending && !hold_vld_q) begin
            hold_d     = rf_rdata;
            hold_vld_d = 1'b1;
        end
        if (push_w) begin
            hold_vld_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (save_start && restore_start) begin
                    err_d = 1'b1;
                end else if (save_start) begin
                    state_d = S_SAVE;
                    raddr_d = FIRST_A;
                    cnt_d   = FIRST_A;
                end else if (restore_start) begin
                    state_d = S_RESTORE;
                    cnt_d   = '0;
                    waddr_d = LAST_A;
                end
            end

            S_SAVE: begin
                if (!stall) begin
                    if (raddr_q == LAST_A) begin
                        // Last read is in flight; its word is pushed next.
                        state_d = S_SAVE_LAST;
                    end else begin
                        raddr_d = raddr_q + 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end

            S_SAVE_LAST: begin
                if (!stall) begin
                    state_d = S_FINISH;
                end
            end

            S_RESTORE: begin
                if (!stall) begin
                    if ((cnt_q != '0) && (waddr_q != FIRST_A)) begin
                        waddr_d = waddr_q - 1'b1;
                    end
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_RESTORE_LAST;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            S_RESTORE_LAST: begin
                if (!stall) begin
                    state_d = S_FINISH;
                end
            end

            S_FINISH: begin
                if (!stall) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any sequence without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            raddr_q    <= '0;
            waddr_q    <= '0;
            err_q      <= 1'b0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            raddr_q    <= raddr_d;
            waddr_q    <= waddr_d;
            err_q      <= err_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end

endmodule

// File: tb/tb_reg_save_restore.sv
// Directed bench for reg_save_restore with a sync-read register file model
// and a simple LIFO stack model.
module tb_reg_save_restore;
    import reg_save_restore_pkg::*;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          save_start = 1'b0;
    logic          restore_start = 1'b0;
    logic          stall = 1'b0;
    logic          busy, done, err;
    logic [AW-1:0] rf_raddr, rf_waddr;
    logic [DW-1:0] rf_rdata, rf_wdata;
    logic          rf_we;
    logic [DW-1:0] stk_d, stk_q;
    logic          stk_push, stk_pop, stk_clear, stk_hold;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    reg_save_restore dut (
        .clk(clk), .reset(reset), .save_start(save_start),
        .restore_start(restore_start), .stall(stall), .busy(busy),
        .done(done), .err(err), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_we(rf_we),
        .stk_d(stk_d), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_q(stk_q), .stk_clear(stk_clear), .stk_hold(stk_hold)
    );

    // Register file model: 16x32, one-cycle read, r0 reads zero, plus a
    // backdoor write port used only to preload or clear registers.
    logic [DW-1:0] rf_mem [16];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;

    always @(posedge clk) begin
        rf_rdata <= (rf_raddr == '0) ? '0 : rf_mem[rf_raddr];
        if (rf_we && rf_waddr != '0) rf_mem[rf_waddr] <= rf_wdata;
        else if (bd_we && bd_addr != '0) rf_mem[bd_addr] <= bd_data;
    end

    // Stack model: q is valid the cycle after a pop and holds until the next.
    logic [DW-1:0] stk_mem [32];
    logic [4:0]    sp;

    always @(posedge clk) begin
        if (reset) begin
            sp    <= '0;
            stk_q <= '0;
        end else if (stk_push) begin
            stk_mem[sp] <= stk_d;
            sp          <= sp + 5'd1;
        end else if (stk_pop) begin
            stk_q <= stk_mem[sp - 5'd1];
            sp    <= sp - 5'd1;
        end
    end

    task automatic load_regs(input bit zero);
        for (int i = 1; i < 16; i++) begin
            @(posedge clk); #1;
            bd_we   = 1'b1;
            bd_addr = AW'(i);
            bd_data = zero ? 32'h0 : 32'h100 + i;
        end
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({busy, done, err, rf_we, stk_push, stk_pop, stk_clear, stk_hold} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {busy, done, err, rf_we, stk_push, stk_pop, stk_clear, stk_hold});
        end
        tests_run++;
        if ({rf_raddr, rf_waddr} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_addr: got raddr %0d waddr %0d expected 0 0", rf_raddr, rf_waddr);
        end
        tests_run++;
        if ({rf_wdata, stk_d} !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got wdata %h stk_d %h expected 0 0", rf_wdata, stk_d);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        $display("[TB] reset: outputs checked");
    endtask

    task automatic test_save();
        int done_cyc = -1, busy_bad = 0, npush = 0, order_bad = 0, conflict = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            save_start = (k == 0);
            @(negedge clk);
            if (busy !== (k >= 1 && k <= 16)) busy_bad++;
            if (stk_push && stk_pop) conflict++;
            if (stk_push === 1'b1) begin
                if (stk_d !== 32'h101 + npush) order_bad++;
                npush++;
            end
            if (done === 1'b1 && done_cyc < 0) done_cyc = k;
        end
        tests_run++;
        if (npush != 15) begin tests_failed++; $display("FAIL save_push_count: got %0d expected 15", npush); end
        tests_run++;
        if (order_bad != 0) begin tests_failed++; $display("FAIL save_push_order: got %0d bad words expected 0", order_bad); end
        tests_run++;
        if (done_cyc != 17) begin tests_failed++; $display("FAIL save_done_cycle: got %0d expected 17", done_cyc); end
        tests_run++;
        if (busy_bad != 0) begin tests_failed++; $display("FAIL save_busy_window: got %0d bad cycles expected 0", busy_bad); end
        tests_run++;
        if (conflict != 0 || sp !== 5'd15) begin
            tests_failed++;
            $display("FAIL save_stack: got conflicts %0d sp %0d expected 0 15", conflict, sp);
        end
        $display("[TB] save: %0d pushes, done at cycle %0d", npush, done_cyc);
    endtask

    // mode 0: no stall; mode 1: stall on every even cycle from cycle 2.
    task automatic test_restore(input int mode);
        int done_cyc = -1, busy_bad = 0, npop = 0, nwrite = 0, order_bad = 0;
        int stall_bad = 0, dup = 0, reg_bad = 0, zero_we = 0;
        int exp_addr = 15;
        int wr_cnt [16];
        int done_exp = (mode == 1) ? 33 : 17;
        int busy_end = (mode == 1) ? 31 : 16;
        for (int i = 0; i < 16; i++) wr_cnt[i] = 0;
        load_regs(1'b1);
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            restore_start = (k == 0);
            stall = (mode == 1) && (k >= 2) && (k % 2 == 0);
            @(negedge clk);
            if (busy !== (k >= 1 && k <= busy_end)) busy_bad++;
            if (stall && (stk_push || stk_pop || rf_we)) stall_bad++;
            if (stk_push || (stk_pop && rf_we && 1'b0)) stall_bad++;
            if (stk_pop === 1'b1) npop++;
            if (rf_we === 1'b1) begin
                if (rf_waddr !== AW'(exp_addr) || rf_wdata !== 32'h100 + exp_addr) order_bad++;
                if (rf_waddr == '0) zero_we++;
                wr_cnt[rf_waddr]++;
                exp_addr--;
                nwrite++;
            end
            if (done === 1'b1 && done_cyc < 0) done_cyc = k;
        end
        stall = 1'b0;
        for (int i = 0; i < 16; i++) if (wr_cnt[i] > 1) dup++;
        for (int i = 1; i < 16; i++) if (rf_mem[i] !== 32'h100 + i) reg_bad++;
        tests_run++;
        if (npop != 15 || nwrite != 15) begin
            tests_failed++;
            $display("FAIL restore%0d_counts: got pops %0d writes %0d expected 15 15", mode, npop, nwrite);
        end
        tests_run++;
        if (order_bad != 0 || zero_we != 0) begin
            tests_failed++;
            $display("FAIL restore%0d_write_order: got %0d bad writes %0d r0 writes expected 0 0", mode, order_bad, zero_we);
        end
        tests_run++;
        if (done_cyc != done_exp) begin
            tests_failed++;
            $display("FAIL restore%0d_done_cycle: got %0d expected %0d", mode, done_cyc, done_exp);
        end
        tests_run++;
        if (reg_bad != 0 || dup != 0) begin
            tests_failed++;
            $display("FAIL restore%0d_regs: got %0d wrong regs %0d duplicate addrs expected 0 0", mode, reg_bad, dup);
        end
        tests_run++;
        if (sp !== 5'd0 || busy_bad != 0 || stall_bad != 0) begin
            tests_failed++;
            $display("FAIL restore%0d_stack: got sp %0d busy_bad %0d strobe_bad %0d expected 0 0 0", mode, sp, busy_bad, stall_bad);
        end
        $display("[TB] restore mode %0d: %0d pops, %0d writes, done at cycle %0d", mode, npop, nwrite, done_cyc);
    endtask

    task automatic test_both_start();
        int err_bad = 0, strobes = 0, busy_cnt = 0;
        logic [4:0] sp0 = sp;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            save_start    = (k == 0);
            restore_start = (k == 0);
            @(negedge clk);
            if (err !== (k == 1)) err_bad++;
            if (stk_push || stk_pop || rf_we) strobes++;
            if (busy) busy_cnt++;
        end
        tests_run++;
        if (err_bad != 0) begin tests_failed++; $display("FAIL both_err_pulse: got %0d bad cycles expected 0", err_bad); end
        tests_run++;
        if (strobes != 0 || busy_cnt != 0 || sp !== sp0) begin
            tests_failed++;
            $display("FAIL both_no_activity: got strobes %0d busy %0d sp %0d expected 0 0 %0d", strobes, busy_cnt, sp, sp0);
        end
        $display("[TB] both starts: err checked");
    endtask

    task automatic test_save_stall();
        int done_cyc = -1, npush = 0, order_bad = 0, stall_bad = 0, err_cnt = 0, mem_bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            save_start    = (k == 0);
            restore_start = (k == 5);
            stall         = (k >= 7 && k <= 9);
            @(negedge clk);
            if (stall && (stk_push || stk_pop || rf_we)) stall_bad++;
            if (err) err_cnt++;
            if (stk_push === 1'b1) begin
                if (stk_d !== 32'h101 + npush) order_bad++;
                npush++;
            end
            if (done === 1'b1 && done_cyc < 0) done_cyc = k;
        end
        for (int i = 0; i < 15; i++) if (stk_mem[i] !== 32'h101 + i) mem_bad++;
        tests_run++;
        if (npush != 15 || order_bad != 0) begin
            tests_failed++;
            $display("FAIL stall_save_pushes: got %0d pushes %0d bad expected 15 0", npush, order_bad);
        end
        tests_run++;
        if (done_cyc != 20) begin tests_failed++; $display("FAIL stall_save_done_cycle: got %0d expected 20", done_cyc); end
        tests_run++;
        if (stall_bad != 0 || err_cnt != 0) begin
            tests_failed++;
            $display("FAIL stall_save_strobes: got %0d stalled strobes %0d err expected 0 0", stall_bad, err_cnt);
        end
        tests_run++;
        if (mem_bad != 0 || sp !== 5'd15) begin
            tests_failed++;
            $display("FAIL stall_save_stack: got %0d bad entries sp %0d expected 0 15", mem_bad, sp);
        end
        $display("[TB] stalled save: %0d pushes, done at cycle %0d", npush, done_cyc);
    endtask

    task automatic test_reset_mid();
        int done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            save_start = (k == 0);
            reset      = (k == 6);
            @(negedge clk);
            if (k == 7) begin
                tests_run++;
                if ({busy, done, stk_push, stk_pop, rf_we} !== 5'b0 || rf_raddr !== '0 || stk_d !== '0) begin
                    tests_failed++;
                    $display("FAIL reset_mid_outputs: got ctl %b raddr %0d stk_d %h expected 00000 0 0",
                             {busy, done, stk_push, stk_pop, rf_we}, rf_raddr, stk_d);
                end
            end
            if (k >= 6 && done) done_cnt++;
        end
        tests_run++;
        if (done_cnt != 0) begin tests_failed++; $display("FAIL reset_mid_no_done: got %0d pulses expected 0", done_cnt); end
        $display("[TB] reset mid-save: outputs checked, rerunning save");
        load_regs(1'b0);
        test_save();
    endtask

    initial begin
        test_reset();
        load_regs(1'b0);
        test_save();
        test_restore(0);
        test_both_start();
        load_regs(1'b0);
        test_save_stall();
        test_restore(1);
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
